fma16_sched: RTL and testbench
==============================

# fma16_sched

Round-robin issue scheduler that shares one combinational fma16 datapath between NREQ requesters. Each cycle it grants at most one pending request, drives that request's operands and control onto the shared fma16 ports, and captures the result into a LAT-stage pipeline. The pipeline carries the requester ID with the result. The block sits between the requesting units and the single fma16 instance and returns tagged results on one response port with valid/ready backpressure.

## Interface

- NREQ, 4, number of requesters (2..8)
- LAT, 2, result pipeline depth in cycles (1..4)
- IDW, $clog2(NREQ), derived localparam, width of requester ID

- clk  in  1  clock; everything is sampled on the rising edge
- reset  in  1  reset, synchronous and active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
- req_op  in  NREQ*54  per-requester operation, requester i at [54*i +: 54], packed {x[15:0], y[15:0], z[15:0], mul, add, negp, negz, roundmode[1:0]}
- fma_x, fma_y, fma_z  out  16 each  operands to the shared fma16
- fma_mul, fma_add, fma_negp, fma_negz  out  1 each  fma16 controls
- fma_roundmode  out  2  fma16 rounding mode
- fma_result  in  16  fma16 result, combinational from the fma_* outputs
- fma_flags  in  4  fma16 flags {invalid, overflow, underflow, inexact}, combinational
- rsp_valid  out  1  result at the output stage
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  IDW  requester that issued the result
- rsp_result  out  16  result
- rsp_flags  out  4  flags
- issue_count  out  16  number of accepted requests, wraps modulo 2^16
- inflight  out  3  number of valid pipeline stages (0..LAT)

## Operation

- **Pipeline.** There are stages 1..LAT, each holding {valid, id, result, flags}. Stage LAT drives the rsp_* outputs.
- **Stall and advance.** stall = rsp_valid & ~rsp_ready, and adv = ~stall.
  - During stall, every stage holds its contents, req_ready = 0, and the pointer and counters hold.
  - During adv, stage k+1 takes stage k. Stage 1 takes {1, granted id, fma_result, fma_flags} when there is a grant, otherwise valid = 0.
- **Arbitration.** Round-robin from pointer ptr (width IDW, reset 0).
  - The winner is the first i in ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ) with req_valid[i] = 1.
  - req_ready = onehot(winner) only when adv and any req_valid is set; otherwise req_ready = 0.
  - On a grant, ptr becomes winner+1 mod NREQ. With no grant, ptr holds.
- **fma_* outputs** carry the fields of req_op for the winner. When there is no grant they carry requester 0's fields; these values are don't-care, but they must not produce X.
- **Counters.** issue_count increments by 1 on every accepted request and wraps from 0xFFFF to 0x0000. inflight is the population count of the stage valid bits, updated registered.
- **Request stability.** A request's req_op must be stable while its req_valid is high and it is not yet granted. The block never drops an accepted request.
- **Same-cycle accept and retire.** When the output is accepted and a new grant happens in the same cycle, both take effect; inflight is unchanged.
- **Reset.** On reset, all valid bits, ptr, issue_count, inflight, rsp_id, rsp_result and rsp_flags go to 0, and req_ready = 0 in the reset cycle. Any in-flight operations are discarded and produce no response.

## Timing

- A request accepted at edge t appears with rsp_valid = 1 after edge t+LAT-1, so it is visible during cycle t+LAT. This holds when no stall occurs in between.
- Each stall cycle adds exactly one cycle to the latency of every in-flight result.
- Throughput is one issue per cycle while rsp_ready = 1.
- Fairness: with all NREQ requesters held valid and no stalls, each requester is granted exactly once in every window of NREQ consecutive cycles.
- req_ready depends combinationally on req_valid, rsp_valid and rsp_ready. No output depends combinationally on fma_result.

## Test plan

1. **Single request, defaults (NREQ=4, LAT=2).** After reset, requester 2 issues x=0x3C00, y=0x4000, z=0x3C00, mul=add=1, rm=0 → req_ready = 0100 in the same cycle; rsp_valid, rsp_id=2, rsp_result=0x4200 two cycles later; issue_count=1.
2. **All requesters valid, rsp_ready=1.** Grants follow 0,1,2,3,0,1…; rsp_id follows the same sequence delayed by LAT; inflight settles at 2.
3. **Backpressure.** Hold rsp_ready=0 for 3 cycles with the pipeline full → outputs frozen, req_ready=0, issue_count frozen. Release → the same results drain in order, none lost or duplicated.
4. **Pointer skip.** ptr=1, only req_valid[0] set → requester 0 granted and ptr becomes 1. Then req_valid={3,1} → 1 granted, then 3.
5. **Reset mid-flight.** Assert reset with 2 ops in flight → the next cycle shows rsp_valid=0, inflight=0, issue_count=0, ptr=0, and neither op ever responds.
6. **Counter wrap.** Preload the count to 0xFFFF via 65535 accepted requests, then issue one more → issue_count=0x0000.

Source files
------------

// File: rtl/fma16_sched.sv
// Round-robin issue scheduler sharing one combinational fma16 among NREQ requesters.
// Granted results travel a LAT-deep tagged pipeline and leave on a valid/ready port.
module fma16_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*54-1:0]   req_op,
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic                 fma_mul,
  output logic                 fma_add,
  output logic                 fma_negp,
  output logic                 fma_negz,
  output logic [1:0]           fma_roundmode,
  input  logic [15:0]          fma_result,
  input  logic [3:0]           fma_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic [15:0]          issue_count,
  output logic [2:0]           inflight
);

  logic [LAT-1:0] r_valid;
  logic [IDW-1:0] r_id     [LAT];
  logic [15:0]    r_result [LAT];
  logic [3:0]     r_flags  [LAT];
  logic [IDW-1:0] r_ptr;
  logic [15:0]    r_issueCount;
  logic [2:0]     r_inflight;

  logic           w_adv;
  logic           w_found;
  logic           w_grant;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_ptrNext;
  logic [53:0]    w_op;
  logic [LAT-1:0] w_validNext;
  logic [2:0]     w_popcount;

  assign w_adv = ~(r_valid[LAT-1] & ~rsp_ready);

  // Search ptr, ptr+1, ... with explicit wrap so non-power-of-two NREQ works.
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW-1:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  assign w_grant   = w_found & w_adv & ~reset;
  assign req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;

  always_comb begin
    logic [IDW:0] nxt;
    nxt = {1'b0, w_winner} + (IDW+1)'(1);
    if (nxt >= (IDW+1)'(NREQ)) nxt = '0;
    w_ptrNext = nxt[IDW-1:0];
  end

  // Idle cycles present requester 0's fields so the shared datapath never sees X.
  assign w_sel         = w_grant ? w_winner : '0;
  assign w_op          = req_op[54*w_sel +: 54];
  assign fma_x         = w_op[53:38];
  assign fma_y         = w_op[37:22];
  assign fma_z         = w_op[21:6];
  assign fma_mul       = w_op[5];
  assign fma_add       = w_op[4];
  assign fma_negp      = w_op[3];
  assign fma_negz      = w_op[2];
  assign fma_roundmode = w_op[1:0];

  always_comb begin
    w_validNext = r_valid;
    if (w_adv) begin
      w_validNext[0] = w_grant;
      for (int k = 1; k < LAT; k++) w_validNext[k] = r_valid[k-1];
    end
  end

  always_comb begin
    w_popcount = '0;
    for (int k = 0; k < LAT; k++) w_popcount = w_popcount + 3'(w_validNext[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= '0;
      r_ptr        <= '0;
      r_issueCount <= '0;
      r_inflight   <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_id[k]     <= '0;
        r_result[k] <= '0;
        r_flags[k]  <= '0;
      end
    end else begin
      r_inflight <= w_popcount;
      if (w_adv) begin
        r_valid     <= w_validNext;
        r_id[0]     <= w_winner;
        r_result[0] <= fma_result;
        r_flags[0]  <= fma_flags;
        for (int k = 1; k < LAT; k++) begin
          r_id[k]     <= r_id[k-1];
          r_result[k] <= r_result[k-1];
          r_flags[k]  <= r_flags[k-1];
        end
        if (w_grant) begin
          r_ptr        <= w_ptrNext;
          r_issueCount <= r_issueCount + 16'd1;
        end
      end
    end
  end

  assign rsp_valid   = r_valid[LAT-1];
  assign rsp_id      = r_id[LAT-1];
  assign rsp_result  = r_result[LAT-1];
  assign rsp_flags   = r_flags[LAT-1];
  assign issue_count = r_issueCount;
  assign inflight    = r_inflight;

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched with a stand-in fma16 driven from the shared ports.
// Expected values come from hand-computed grant orders and the stand-in function.
module tb_fma16_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam logic [53:0] TEST1_OP = {16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*54-1:0] req_op;
  logic [15:0]       fma_x, fma_y, fma_z;
  logic              fma_mul, fma_add, fma_negp, fma_negz;
  logic [1:0]        fma_roundmode;
  logic [15:0]       fma_result;
  logic [3:0]        fma_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_result;
  logic [3:0]        rsp_flags;
  logic [15:0]       issue_count;
  logic [2:0]        inflight;

  int checks = 0;
  int errors = 0;

  fma16_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode), .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .issue_count(issue_count), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in fma16: exact for the 1*2+1 vector, a cheap operand hash otherwise.
  function automatic logic [19:0] fmaModel(input logic [53:0] op);
    logic [15:0] x, y, z, res;
    logic [3:0]  fl;
    if (op == TEST1_OP) return {4'h0, 16'h4200};
    x   = op[53:38];
    y   = op[37:22];
    z   = op[21:6];
    res = x ^ {y[14:0], y[15]} ^ {z[0], z[15:1]} ^ {op[5:0], 10'h000};
    fl  = x[3:0] ^ z[7:4] ^ op[3:0];
    return {fl, res};
  endfunction

  function automatic logic [53:0] mkOp(input int id, input int seq);
    logic [15:0] x, y, z;
    x = 16'h3000 + 16'(id * 257 + seq);
    y = 16'h4100 + 16'(id * 19 + seq * 7);
    z = 16'h0800 + 16'(id * 1021 + seq * 3);
    return {x, y, z, 1'b1, id[0], id[1], seq[0], 2'(id + seq)};
  endfunction

  always_comb begin
    {fma_flags, fma_result} = fmaModel({fma_x, fma_y, fma_z, fma_mul, fma_add,
                                        fma_negp, fma_negz, fma_roundmode});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
    req_valid = valid;
    rsp_ready = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadOps(input int seq);
    for (int i = 0; i < NREQ; i++) req_op[54*i +: 54] = mkOp(i, seq);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    loadOps(1);
    tick();
    tick();
    applyStimulus(4'b1111, 1'b1);
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    tick();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_inflight", 32'(inflight), 32'h0);
    checkOutput("reset_issue_count", 32'(issue_count), 32'h0);
    reset = 1'b0;

    $display("[TB] single request");
    req_op[54*2 +: 54] = TEST1_OP;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("t1_req_ready", 32'(req_ready), 32'h4);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t1_issue_count", 32'(issue_count), 32'd1);
    checkOutput("t1_rsp_valid_early", 32'(rsp_valid), 32'h0);
    checkOutput("t1_inflight_1", 32'(inflight), 32'd1);
    tick();
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("t1_rsp_result", 32'(rsp_result), 32'h4200);
    checkOutput("t1_rsp_flags", 32'(rsp_flags), 32'h0);
    tick();
    checkOutput("t1_rsp_valid_done", 32'(rsp_valid), 32'h0);
    checkOutput("t1_inflight_0", 32'(inflight), 32'd0);

    $display("[TB] all requesters valid");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    loadOps(2);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("t2_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      checkOutput("t2_inflight", 32'(inflight), (k == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t2_rsp_id", 32'(rsp_id), 32'((k - 1) % 4));
        checkOutput("t2_rsp_result", 32'(rsp_result), 32'(fmaModel(mkOp((k - 1) % 4, 2)) & 20'hFFFF));
      end
    end

    $display("[TB] backpressure");
    applyStimulus(4'b1111, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput("t3_req_ready_stall", 32'(req_ready), 32'h0);
      tick();
      checkOutput("t3_rsp_valid_hold", 32'(rsp_valid), 32'h1);
      checkOutput("t3_rsp_id_hold", 32'(rsp_id), 32'd2);
      checkOutput("t3_rsp_result_hold", 32'(rsp_result), 32'(fmaModel(mkOp(2, 2)) & 20'hFFFF));
      checkOutput("t3_issue_hold", 32'(issue_count), 32'd8);
      checkOutput("t3_inflight_hold", 32'(inflight), 32'd2);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_req_ready_idle", 32'(req_ready), 32'h0);
    tick();
    checkOutput("t3_drain_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t3_drain_id", 32'(rsp_id), 32'd3);
    checkOutput("t3_drain_result", 32'(rsp_result), 32'(fmaModel(mkOp(3, 2)) & 20'hFFFF));
    checkOutput("t3_drain_inflight", 32'(inflight), 32'd1);
    tick();
    checkOutput("t3_empty_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t3_empty_inflight", 32'(inflight), 32'd0);
    checkOutput("t3_issue_final", 32'(issue_count), 32'd8);

    $display("[TB] pointer skip");
    loadOps(4);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t4_grant_a", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t4_grant_wrap", 32'(req_ready), 32'h1);
    tick();
    checkOutput("t4_rsp_id_a", 32'(rsp_id), 32'd0);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("t4_grant_1", 32'(req_ready), 32'h2);
    tick();
    checkOutput("t4_rsp_id_b", 32'(rsp_id), 32'd0);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("t4_grant_3", 32'(req_ready), 32'h8);
    tick();
    checkOutput("t4_rsp_id_c", 32'(rsp_id), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("t4_rsp_id_d", 32'(rsp_id), 32'd3);
    checkOutput("t4_issue_count", 32'(issue_count), 32'd12);
    tick();
    checkOutput("t4_rsp_valid_done", 32'(rsp_valid), 32'h0);

    $display("[TB] reset mid-flight");
    loadOps(5);
    applyStimulus(4'b0011, 1'b1);
    tick();
    applyStimulus(4'b0011, 1'b1);
    tick();
    checkOutput("t5_inflight_2", 32'(inflight), 32'd2);
    reset = 1'b1;
    applyStimulus(4'b0011, 1'b1);
    checkOutput("t5_req_ready_reset", 32'(req_ready), 32'h0);
    tick();
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t5_inflight", 32'(inflight), 32'd0);
    checkOutput("t5_issue_count", 32'(issue_count), 32'd0);
    checkOutput("t5_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("t5_rsp_result", 32'(rsp_result), 32'h0);
    checkOutput("t5_rsp_flags", 32'(rsp_flags), 32'h0);
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput("t5_no_response", 32'(rsp_valid), 32'h0);
    end
    applyStimulus(4'b1111, 1'b1);
    checkOutput("t5_ptr_zero", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();

    $display("[TB] counter wrap");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("t6_count_ffff", 32'(issue_count), 32'hFFFF);
    tick();
    checkOutput("t6_count_wrap", 32'(issue_count), 32'h0);
    checkOutput("t6_inflight", 32'(inflight), 32'd2);
    applyStimulus(4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
